// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller:
// forward-select encodings, default mul/div latencies and small match helpers.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_PIPE = 2'd0,
        FWD_W    = 2'd1,
        FWD_M    = 2'd2
    } fwd_sel_e;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 10;

    typedef logic [1:0] tval_t;
    typedef logic [4:0] reg_idx_t;

    // $0 never matches: it is hard-wired to zero and must not forward or stall.
    function automatic logic fwd_match(logic we, reg_idx_t dst, reg_idx_t src);
        return we && (dst == src) && (src != '0);
    endfunction

    function automatic logic [1:0] fwd_pick(logic m_hit, tval_t m_tnew, logic w_hit);
        if (m_hit && (m_tnew == '0)) return FWD_M;
        if (w_hit)                   return FWD_W;
        return FWD_PIPE;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-status inputs and hazard-decision outputs of hazard_ctrl;
// master drives stage status, slave (the controller) returns stall/forward selects.
interface hazard_ctrl_if;
    import hazard_pkg::*;

    reg_idx_t D_rs, D_rt;
    tval_t    D_rs_tuse, D_rt_tuse;
    logic     D_is_md;
    reg_idx_t E_rs, E_rt, M_rt;
    reg_idx_t E_dst, M_dst, W_dst;
    logic     E_we, M_we, W_we;
    tval_t    E_tnew, M_tnew;
    logic     E_md_start, E_md_div;

    logic       stall, E_clr, md_busy;
    logic [1:0] fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt;
    logic       fwd_M_rt;

    modport master (
        output D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
        output E_rs, E_rt, M_rt, E_dst, M_dst, W_dst,
        output E_we, M_we, W_we, E_tnew, M_tnew, E_md_start, E_md_div,
        input  stall, E_clr, md_busy,
        input  fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );

    modport slave (
        input  D_rs, D_rt, D_rs_tuse, D_rt_tuse, D_is_md,
        input  E_rs, E_rt, M_rt, E_dst, M_dst, W_dst,
        input  E_we, M_we, W_we, E_tnew, M_tnew, E_md_start, E_md_div,
        output stall, E_clr, md_busy,
        output fwd_D_rs, fwd_D_rt, fwd_E_rs, fwd_E_rt, fwd_M_rt
    );

endinterface

// File: rtl/hazard_ctrl_md_busy_counter.sv
// Busy tracker for the multi-cycle multiply/divide unit: loads the operation
// latency when an md op enters E and counts down to idle.
module md_busy_counter
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic div,
    output logic busy
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_LAT);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_LAT);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic [CW-1:0] w_load;

    assign w_load = div ? DIV_LOAD : MULT_LOAD;

    // NOTE: reset is synchronous and checked first, so it beats a coincident start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
        end else if (start) begin
            r_cnt   <= w_load;
            r_busy  <= (w_load != '0);
            r_state <= (w_load != '0) ? BUSY : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    r_busy <= 1'b0;
                end
                BUSY: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Central stall/forward decision logic for the five-stage MIPS pipeline.
// Optional stall-cycle statistics counter built when HAZARD_STAT_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
`ifdef HAZARD_STAT_EN
    ,
    output logic [31:0]   stall_cnt
`endif
);

    logic w_e_hit_rs, w_e_hit_rt, w_m_hit_rs, w_m_hit_rt, w_w_hit_rs, w_w_hit_rt;
    logic w_me_hit_rs, w_me_hit_rt, w_we_hit_rs, w_we_hit_rt;
    logic w_stall_rs, w_stall_rt, w_md_stall, w_md_busy, w_stall;

    assign w_e_hit_rs = fwd_match(hz.E_we, hz.E_dst, hz.D_rs);
    assign w_e_hit_rt = fwd_match(hz.E_we, hz.E_dst, hz.D_rt);
    assign w_m_hit_rs = fwd_match(hz.M_we, hz.M_dst, hz.D_rs);
    assign w_m_hit_rt = fwd_match(hz.M_we, hz.M_dst, hz.D_rt);
    assign w_w_hit_rs = fwd_match(hz.W_we, hz.W_dst, hz.D_rs);
    assign w_w_hit_rt = fwd_match(hz.W_we, hz.W_dst, hz.D_rt);

    assign w_me_hit_rs = fwd_match(hz.M_we, hz.M_dst, hz.E_rs);
    assign w_me_hit_rt = fwd_match(hz.M_we, hz.M_dst, hz.E_rt);
    assign w_we_hit_rs = fwd_match(hz.W_we, hz.W_dst, hz.E_rs);
    assign w_we_hit_rt = fwd_match(hz.W_we, hz.W_dst, hz.E_rt);

    assign hz.fwd_D_rs = fwd_pick(w_m_hit_rs,  hz.M_tnew, w_w_hit_rs);
    assign hz.fwd_D_rt = fwd_pick(w_m_hit_rt,  hz.M_tnew, w_w_hit_rt);
    assign hz.fwd_E_rs = fwd_pick(w_me_hit_rs, hz.M_tnew, w_we_hit_rs);
    assign hz.fwd_E_rt = fwd_pick(w_me_hit_rt, hz.M_tnew, w_we_hit_rt);
    assign hz.fwd_M_rt = fwd_match(hz.W_we, hz.W_dst, hz.M_rt);

    // A producer stalls D only if its result arrives later than D needs it.
    assign w_stall_rs = (hz.D_rs != '0) &&
                        ((w_e_hit_rs && (hz.E_tnew > hz.D_rs_tuse)) ||
                         (w_m_hit_rs && (hz.M_tnew > hz.D_rs_tuse)));
    assign w_stall_rt = (hz.D_rt != '0) &&
                        ((w_e_hit_rt && (hz.E_tnew > hz.D_rt_tuse)) ||
                         (w_m_hit_rt && (hz.M_tnew > hz.D_rt_tuse)));
    assign w_md_stall = hz.D_is_md && (hz.E_md_start || w_md_busy);
    assign w_stall    = w_stall_rs || w_stall_rt || w_md_stall;

    assign hz.stall   = w_stall;
    assign hz.E_clr   = w_stall;
    assign hz.md_busy = w_md_busy;

    md_busy_counter #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_busy (
        .clk   (clk),
        .rst   (rst),
        .start (hz.E_md_start),
        .div   (hz.E_md_div),
        .busy  (w_md_busy)
    );

`ifdef HAZARD_STAT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed pipeline scenarios plus random
// stage status, checked against a cycle-indexed reference model.
module tb_hazard_ctrl;

    localparam int MLAT = 5;
    localparam int DLAT = 10;

    typedef struct {
        logic       rst;
        logic [4:0] d_rs, d_rt;
        logic [1:0] d_rs_tuse, d_rt_tuse;
        logic       d_is_md;
        logic [4:0] e_rs, e_rt, m_rt, e_dst, m_dst, w_dst;
        logic       e_we, m_we, w_we;
        logic [1:0] e_tnew, m_tnew;
        logic       md_start, md_div;
    } stim_t;

    typedef struct {
        int          cyc;
        logic        stall, md_busy, fwd_m_rt;
        logic [1:0]  fd_rs, fd_rt, fe_rs, fe_rt;
        logic [31:0] scnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hazard_ctrl_if hz ();
`ifdef HAZARD_STAT_EN
    logic [31:0] stall_cnt;
`endif

    hazard_ctrl #(.MULT_LAT(MLAT), .DIV_LAT(DLAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .hz        (hz)
`ifdef HAZARD_STAT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          busy_until = -1;   // last cycle index in which md unit is busy
    logic [31:0] scnt     = 0;
    stim_t       prev;
    logic        prev_stall = 1'b0;

    task automatic check(string name, int c, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, c, act, exp);
        end
    endtask

    function automatic stim_t idle_stim();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic bit hit(logic we, logic [4:0] dst, logic [4:0] src);
        return we && (dst == src) && (src != 5'd0);
    endfunction

    function automatic logic [1:0] sel(stim_t s, logic [4:0] src);
        if (hit(s.m_we, s.m_dst, src) && s.m_tnew == 2'd0) return 2'd2;
        if (hit(s.w_we, s.w_dst, src)) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit data_stall(stim_t s, logic [4:0] src, logic [1:0] tuse);
        if (src == 5'd0) return 1'b0;
        return (hit(s.e_we, s.e_dst, src) && s.e_tnew > tuse) ||
               (hit(s.m_we, s.m_dst, src) && s.m_tnew > tuse);
    endfunction

    task automatic apply(stim_t s);
        rst           = s.rst;
        hz.D_rs       = s.d_rs;       hz.D_rt       = s.d_rt;
        hz.D_rs_tuse  = s.d_rs_tuse;  hz.D_rt_tuse  = s.d_rt_tuse;
        hz.D_is_md    = s.d_is_md;
        hz.E_rs       = s.e_rs;       hz.E_rt       = s.e_rt;
        hz.M_rt       = s.m_rt;
        hz.E_dst      = s.e_dst;      hz.M_dst      = s.m_dst;  hz.W_dst = s.w_dst;
        hz.E_we       = s.e_we;       hz.M_we       = s.m_we;   hz.W_we  = s.w_we;
        hz.E_tnew     = s.e_tnew;     hz.M_tnew     = s.m_tnew;
        hz.E_md_start = s.md_start;   hz.E_md_div   = s.md_div;
    endtask

    // One pipeline cycle: commit the previous cycle at the edge, then present s.
    task automatic step(stim_t s);
        exp_t e;
        @(posedge clk);
        if (prev.rst) begin
            busy_until = -1;
            scnt       = 0;
        end else begin
            if (prev.md_start) busy_until = cyc + (prev.md_div ? DLAT : MLAT);
            if (prev_stall && scnt != 32'hFFFF_FFFF) scnt = scnt + 1;
        end
        cyc++;
        #1;
        apply(s);
        e.cyc      = cyc;
        e.md_busy  = (cyc <= busy_until);
        e.stall    = data_stall(s, s.d_rs, s.d_rs_tuse) ||
                     data_stall(s, s.d_rt, s.d_rt_tuse) ||
                     (s.d_is_md && (s.md_start || e.md_busy));
        e.fd_rs    = sel(s, s.d_rs);
        e.fd_rt    = sel(s, s.d_rt);
        e.fe_rs    = sel(s, s.e_rs);
        e.fe_rt    = sel(s, s.e_rt);
        e.fwd_m_rt = hit(s.w_we, s.w_dst, s.m_rt);
        e.scnt     = scnt;
        sb_q.push_back(e);
        prev       = s;
        prev_stall = e.stall;
    endtask

    // Monitor: outputs are valid every cycle, so compare once per pushed cycle.
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            check("stall",    e.cyc, 32'(hz.stall),    32'(e.stall));
            check("E_clr",    e.cyc, 32'(hz.E_clr),    32'(e.stall));
            check("md_busy",  e.cyc, 32'(hz.md_busy),  32'(e.md_busy));
            check("fwd_D_rs", e.cyc, 32'(hz.fwd_D_rs), 32'(e.fd_rs));
            check("fwd_D_rt", e.cyc, 32'(hz.fwd_D_rt), 32'(e.fd_rt));
            check("fwd_E_rs", e.cyc, 32'(hz.fwd_E_rs), 32'(e.fe_rs));
            check("fwd_E_rt", e.cyc, 32'(hz.fwd_E_rt), 32'(e.fe_rt));
            check("fwd_M_rt", e.cyc, 32'(hz.fwd_M_rt), 32'(e.fwd_m_rt));
`ifdef HAZARD_STAT_EN
            check("stall_cnt", e.cyc, stall_cnt, e.scnt);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        prev = idle_stim();
        prev.rst = 1'b1;
        apply(prev);

        s = idle_stim(); s.rst = 1'b1;
        step(s);                                   // reset-state cycle
        step(idle_stim());

        // lw $1 in E, addu in D reads $1 (tuse=1)
        s = idle_stim(); s.e_dst = 5'd1; s.e_we = 1; s.e_tnew = 2'd2;
        s.d_rs = 5'd1; s.d_rs_tuse = 2'd1; s.d_rt = 5'd5; s.d_rt_tuse = 2'd1;
        step(s);
        s = idle_stim(); s.m_dst = 5'd1; s.m_we = 1; s.m_tnew = 2'd1;
        s.d_rs = 5'd1; s.d_rs_tuse = 2'd1;
        step(s);
        s = idle_stim(); s.w_dst = 5'd1; s.w_we = 1; s.e_rs = 5'd1;
        s.m_dst = 5'd1; s.m_we = 1; s.m_tnew = 2'd0;
        step(s);

        // beq reads $2 in D: M result, then W result only
        s = idle_stim(); s.d_rs = 5'd2; s.m_dst = 5'd2; s.m_we = 1;
        step(s);
        s = idle_stim(); s.d_rs = 5'd2; s.w_dst = 5'd2; s.w_we = 1;
        step(s);

        // M and W both write $3; then all targeting $0
        s = idle_stim(); s.e_rs = 5'd3; s.e_rt = 5'd3; s.m_dst = 5'd3; s.m_we = 1;
        s.w_dst = 5'd3; s.w_we = 1; s.m_rt = 5'd3;
        step(s);
        s = idle_stim(); s.d_rs = 5'd0; s.d_rt = 5'd0; s.e_rs = 5'd0; s.m_rt = 5'd0;
        s.e_dst = 5'd0; s.e_we = 1; s.e_tnew = 2'd3; s.m_we = 1; s.m_tnew = 2'd3; s.w_we = 1;
        step(s);

        // div starts, mflo held in D through the busy window
        s = idle_stim(); s.md_start = 1; s.md_div = 1;
        step(s);
        for (int i = 0; i < DLAT + 2; i++) begin
            s = idle_stim(); s.d_is_md = 1;
            step(s);
        end

        // mult starts, reset two cycles later, mfhi afterwards not held
        s = idle_stim(); s.md_start = 1;
        step(s);
        step(idle_stim());
        s = idle_stim(); s.rst = 1;
        step(s);
        s = idle_stim(); s.d_is_md = 1;
        step(s);
        step(s);

        // rst together with start; then three stall cycles and reset
        s = idle_stim(); s.rst = 1; s.md_start = 1; s.md_div = 1;
        step(s);
        for (int i = 0; i < 3; i++) begin
            s = idle_stim(); s.d_rt = 5'd4; s.e_dst = 5'd4; s.e_we = 1; s.e_tnew = 2'd2;
            step(s);
        end
        step(idle_stim());
        s = idle_stim(); s.rst = 1;
        step(s);
        step(idle_stim());

        // randomized stage status over a small register window to force matches
        for (int i = 0; i < 600; i++) begin
            s = idle_stim();
            s.rst       = ($urandom_range(0, 79) == 0);
            s.d_rs      = 5'($urandom_range(0, 3));
            s.d_rt      = 5'($urandom_range(0, 3));
            s.d_rs_tuse = 2'($urandom_range(0, 3));
            s.d_rt_tuse = 2'($urandom_range(0, 3));
            s.d_is_md   = ($urandom_range(0, 3) == 0);
            s.e_rs      = 5'($urandom_range(0, 3));
            s.e_rt      = 5'($urandom_range(0, 3));
            s.m_rt      = 5'($urandom_range(0, 3));
            s.e_dst     = 5'($urandom_range(0, 3));
            s.m_dst     = 5'($urandom_range(0, 3));
            s.w_dst     = 5'($urandom_range(0, 3));
            s.e_we      = 1'($urandom_range(0, 1));
            s.m_we      = 1'($urandom_range(0, 1));
            s.w_we      = 1'($urandom_range(0, 1));
            s.e_tnew    = 2'($urandom_range(0, 3));
            s.m_tnew    = 2'($urandom_range(0, 3));
            s.md_start  = ($urandom_range(0, 9) == 0);
            s.md_div    = 1'($urandom_range(0, 1));
            step(s);
        end

        @(negedge clk);
        #1;
        check("sb_drain", cyc, 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Central hazard controller for the five-stage MIPS pipeline. It decides each cycle whether the F/D pipeline register must freeze and whether the D/E register must take a bubble. It produces forwarding mux selects for the D, E and M stages. It also tracks the multi-cycle multiply/divide unit with an internal busy counter, so that HI/LO-dependent instructions are held in D until the unit is free.

## Interface
Parameters:
- MULT_LAT, default 5: busy cycles after mult/multu enters E
- DIV_LAT, default 10: busy cycles after div/divu enters E

Ports:
- clk  in  1  pipeline clock; the clock is the same one that drives every pipeline register
- rst  in  1  synchronous, active-high reset
- D_rs, D_rt  in  5 each  source registers of the instruction in D
- D_rs_tuse, D_rt_tuse  in  2 each  cycles until that source is consumed (0 = consumed in D)
- D_is_md  in  1  the D instruction is mult/div/mfhi/mflo/mthi/mtlo
- E_dst, M_dst, W_dst  in  5 each  destination register per stage
- E_we, M_we, W_we  in  1 each  that stage writes the register file
- E_tnew, M_tnew  in  2 each  cycles until the result is produced in that stage
- E_md_start  in  1  a mult/multu/div/divu is in E this cycle
- E_md_div  in  1  with E_md_start: 1 = div/divu, 0 = mult/multu
- stall  out  1  freeze PC and F/D; insert a bubble into D/E
- E_clr  out  1  clear D/E; equals stall
- md_busy  out  1  the multiply/divide unit is computing
- fwd_D_rs, fwd_D_rt  out  2 each  D-stage compare-operand select
- fwd_E_rs, fwd_E_rt  out  2 each  ALU-operand select
- fwd_M_rt  out  1  store-data select: 1 = W result
- stall_cnt  out  32  stall-cycle count; present only with HAZARD_STAT_EN

## Operation
- Forward select encoding: 0 = pipeline value, 1 = W result, 2 = M result.
- A forwarding match requires all of: stage we=1, dst equals the source register, source register is nonzero.
- D-stage select: M match with M_tnew==0 gives 2; otherwise a W match gives 1; otherwise 0.
- E-stage select: same rule, applied to the rs/rt fields latched into E. Pass those fields in as E_rs and E_rt (5-bit inputs each).
- fwd_M_rt = 1 when W matches M_rt.
- Data stall for rs:
  - D_rs is nonzero, and
  - either (E match AND E_tnew > D_rs_tuse) or (M match AND M_tnew > D_rs_tuse).
- Data stall for rt: the same rule using D_rt and D_rt_tuse.
- MD stall: D_is_md AND (E_md_start OR md_busy).
- stall is the OR of the rs data stall, the rt data stall and the MD stall.
- MD busy counter, states IDLE and BUSY:
  - IDLE to BUSY: on E_md_start, load MULT_LAT or DIV_LAT according to E_md_div.
  - In BUSY: decrement once per cycle.
  - BUSY to IDLE: when the count reaches 0.
  - md_busy = (count != 0).
- E_md_start while BUSY reloads the counter. This is defined behaviour, although the MD stall normally prevents it.

## Timing
- stall, E_clr and all forwarding selects are combinational from the inputs and the counter; there is no added latency.
- E_md_start high at edge T: md_busy is high from T+1 through T+LAT inclusive, then low at T+LAT+1.
- The MD stall holds an mfhi that is in D at T through cycle T+LAT.
- Reset values: counter 0, md_busy 0, stall_cnt 0. Combinational outputs follow from the inputs.
- rst during BUSY: the counter clears at that edge and md_busy is 0 on the next cycle.
- rst together with E_md_start: rst wins.

## Configuration
- HAZARD_STAT_EN defined:
  - stall_cnt increments each cycle stall=1.
  - It saturates at 0xFFFFFFFF.
  - It is cleared by rst.
- HAZARD_STAT_EN undefined: the port and the counter are absent, with zero logic.

## Structure
- Package hazard_pkg holds:
  - the FWD_PIPE/FWD_W/FWD_M encodings
  - the default MULT_LAT and DIV_LAT constants
  - the 2-bit tuse/tnew typedef
- Sub-module md_busy_counter:
  - inputs: clk, rst, start, div
  - output: busy
  - parameters: MULT_LAT, DIV_LAT

## Test plan
- lw $1 in E (E_tnew=2), D addu uses $1 with tuse=1 -> stall=1, E_clr=1. Next cycle M_tnew=1 -> stall=1; then M_tnew=0 -> stall=0 and fwd_E_rs=2.
- beq in D reads $2 (tuse=0), M has $2 with M_tnew=0 -> stall=0, fwd_D_rs=2. Same with a W match only -> fwd_D_rs=1.
- M and W both write $3, E reads $3 -> fwd_E_rs=2 (M priority). Destination $0 -> all selects 0 and stall=0.
- div starts at T, mflo in D at T+1 -> stall high T+1..T+10, low at T+11, md_busy low at T+11.
- mult starts, rst asserted at T+2 -> md_busy=0 at T+3. An mfhi in D at T+3 is not stalled.
- HAZARD_STAT_EN defined, three stall cycles then rst -> stall_cnt reads 3, then 0 after reset.
